// File: rtl/ps2_key_rx_pkg.sv
// Shared PS/2 definitions: prefix bytes, ps2_key bit positions, frame FSM states
// and the odd-parity helper used by the receiver.
package ps2_key_rx_pkg;

  localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL   = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

  localparam int KEY_TOGGLE = 10;
  localparam int KEY_PRESS  = 9;
  localparam int KEY_EXT    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  // Device frames carry odd parity over the 8 data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_key_rx_if.sv
// Bundle of the raw PS/2 pins and the decoded key bus seen by the ZX81 core.
interface ps2_key_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        rx_error;

  modport master (output ps2_clk, output ps2_data, input ps2_key, input rx_error);
  modport slave  (input ps2_clk, input ps2_data, output ps2_key, output rx_error);
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronisers on both PS/2 lines, a run-length glitch filter on the
// clock line and a single-cycle strobe on each filtered falling edge.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_filt;
  logic [CW-1:0] run_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the sync chain work.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_filt  <= 1'b1;
      run_cnt   <= '0;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      fall      <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
        // FILTER_LEN-th consecutive differing sample: accept the new level.
        clk_filt <= clk_sync[1];
        run_cnt  <= '0;
        fall     <= clk_filt;
      end else begin
        run_cnt <= run_cnt + CW'(1);
      end
    end
  end

  assign data_s = data_sync[1];

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: frame FSM, E0/F0 prefix folding into toggle-announced
// key events, and an optional mid-frame watchdog enabled by PS2_WATCHDOG_EN.
module ps2_key_rx
  import ps2_key_rx_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 12500
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  ps2_key_rx_if.slave  bus
);

  logic      fall;
  logic      data_s;
  rx_state_t state, state_next;
  logic [3:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       par_bit;
  logic       ext, rel;
  logic [10:0] key_q;
  logic        err_q;
  logic        start_en, shift_en, par_en, byte_valid, frame_err, timeout;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ps2_clk  (bus.ps2_clk),
    .ps2_data (bus.ps2_data),
    .fall     (fall),
    .data_s   (data_s)
  );

`ifdef PS2_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  logic [WW-1:0] wd_cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                                 wd_cnt <= '0;
    else if (fall || state == ST_IDLE || timeout) wd_cnt <= '0;
    else                                          wd_cnt <= wd_cnt + WW'(1);
  end

  // A coinciding fall wins over the timeout.
  assign timeout = (state != ST_IDLE) && !fall && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    start_en   = 1'b0;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    if (timeout) begin
      state_next = ST_IDLE;
      frame_err  = 1'b1;
    end else if (fall) begin
      unique case (state)
        ST_IDLE: begin
          if (!data_s) begin
            state_next = ST_DATA;
            start_en   = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end
        ST_DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == 4'd7) state_next = ST_PARITY;
        end
        ST_PARITY: begin
          par_en     = 1'b1;
          state_next = ST_STOP;
        end
        ST_STOP: begin
          state_next = ST_IDLE;
          if (data_s && odd_parity_ok(shift_reg, par_bit)) byte_valid = 1'b1;
          else                                             frame_err  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
    end else begin
      if (start_en) bit_cnt <= '0;
      if (shift_en) begin
        shift_reg <= {data_s, shift_reg[7:1]};
        if (bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
      end
      if (par_en) par_bit <= data_s;
    end
  end

  // Prefix folding: E0/F0 only set flags; the next real scancode emits one event.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ext   <= 1'b0;
      rel   <= 1'b0;
      key_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= frame_err;
      if (frame_err) begin
        ext <= 1'b0;
        rel <= 1'b0;
      end else if (byte_valid) begin
        case (shift_reg)
          PS2_PFX_EXT:   ext <= 1'b1;
          PS2_PFX_REL:   rel <= 1'b1;
          PS2_PFX_PAUSE: ;
          8'h00, 8'hFF: begin
            ext <= 1'b0;
            rel <= 1'b0;
          end
          default: begin
            key_q[KEY_TOGGLE] <= ~key_q[KEY_TOGGLE];
            key_q[KEY_PRESS]  <= ~rel;
            key_q[KEY_EXT]    <= ext;
            key_q[7:0]        <= shift_reg;
            ext               <= 1'b0;
            rel               <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ps2_key  = key_q;
  assign bus.rx_error = err_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Scoreboard bench for ps2_key_rx: stimulus pushes expected key events / error
// pulses, a negedge monitor pops and compares whenever the DUT presents one.
module tb_ps2_key_rx;
  import ps2_key_rx_pkg::*;

  localparam int HALF = 20;
  localparam logic [11:0] EXP_ERR = 12'h800;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  ps2_key_rx_if bus ();

  ps2_key_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(12500)) dut (
    .clk_sys (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  logic [11:0] exp_q[$];
  logic [10:0] prev_key = '0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input string name, input logic [11:0] act);
    logic [11:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: got %h with nothing expected at %0t", name, act, $time);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_key = '0;
    end else begin
      if (bus.rx_error) pop_check("rx_error", EXP_ERR);
      if (bus.ps2_key !== prev_key) begin
        pop_check("ps2_key", {1'b0, bus.ps2_key});
        prev_key = bus.ps2_key;
      end
    end
  end

  task automatic expect_key(input logic [10:0] k);
    exp_q.push_back({1'b0, k});
  endtask

  task automatic expect_err();
    exp_q.push_back(EXP_ERR);
  endtask

  task automatic send_bit(input logic d, input bit glitch);
    bus.ps2_data = d;
    if (glitch) begin
      repeat (HALF / 2) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      bus.ps2_clk = 1'b1;
      repeat (HALF - HALF / 2 - 3) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    bus.ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit glitch);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch && (i == 3));
    send_bit(par, 1'b0);
    send_bit(~bad_stop, 1'b0);
    bus.ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_partial(input logic [3:0] nib);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(nib[i], 1'b0);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, 12'(exp_q.size()), 12'd0);
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_key", {1'b0, bus.ps2_key}, 12'h000);
    check("reset_err", {11'h0, bus.rx_error}, 12'h000);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_key", {1'b0, bus.ps2_key}, 12'h000);

    // Plain make, then break via F0.
    expect_key(11'h61C); send_good(8'h1C);
    expect_key(11'h01C); send_good(8'hF0); send_good(8'h1C);
    // Extended break then a plain make of the same code.
    expect_key(11'h575); send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
    expect_key(11'h275); send_good(8'h75);
    // Bad parity, bad stop, then recovery.
    expect_err(); send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    expect_err(); send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    expect_key(11'h61C); send_good(8'h1C);
    // An error after E0 drops the extended flag.
    send_good(8'hE0);
    expect_err(); send_frame(8'h33, 1'b1, 1'b0, 1'b0);
    expect_key(11'h26B); send_good(8'h6B);
    // E1 is ignored and keeps pending flags.
    expect_key(11'h614); send_good(8'hE1); send_good(8'h14);
    expect_key(11'h014); send_good(8'hF0); send_good(8'hE1); send_good(8'h14);
    // Overrun bytes clear pending prefixes.
    expect_key(11'h61C); send_good(8'hF0); send_good(8'h00); send_good(8'h1C);
    expect_key(11'h21C); send_good(8'hE0); send_good(8'hFF); send_good(8'h1C);
    // Short low glitch on ps2_clk mid-frame must not sample a bit.
    expect_key(11'h629); send_frame(8'h29, 1'b0, 1'b0, 1'b1);
    // Lone clock pulse with data high while idle.
    expect_err(); send_bit(1'b1, 1'b0);
    repeat (2 * HALF) @(negedge clk);
    wait_drain("drain_main", 200);

    // Reset in the middle of a frame after an E0 prefix.
    send_good(8'hE0);
    send_partial(4'hA);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_key", {1'b0, bus.ps2_key}, 12'h000);
    check("midreset_err", {11'h0, bus.rx_error}, 12'h000);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    expect_key(11'h629); send_good(8'h29);
    wait_drain("drain_reset", 200);

`ifdef PS2_WATCHDOG_EN
    // Clock stalls after 4 data bits: watchdog aborts, next frame decodes.
    expect_err();
    send_partial(4'h5);
    wait_drain("drain_timeout", 15000);
    expect_key(11'h229); send_good(8'h29);
    wait_drain("drain_after_timeout", 200);
`endif

    repeat (50) @(negedge clk);
    check("no_spurious", 12'(exp_q.size()), 12'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
